// File: rtl/memory_responder.sv
// Single-cycle banked memory responder: byte/half/word loads and stores with
// registered data, alignment/range exceptions and legal-access counters.
package memory_responder_pkg;
  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef logic [3:0] mem_exception_mask_t;
  localparam int MEM_EXC_MISALIGNED   = 0;
  localparam int MEM_EXC_OUT_OF_RANGE = 1;
endpackage

module memory_responder_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  // Storage is deliberately not reset; contents survive rst.
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module memory_responder
  import memory_responder_pkg::*;
#(
  parameter logic [3:0] BANK_ID     = 4'h1,
  parameter int         DEPTH_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wr_data,
  input  logic                mem_wr_ena,
  input  mem_access_t         mem_access,
  output logic [31:0]         mem_rd_data,
  output mem_exception_mask_t mem_exception,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);

  logic                        out_of_range, misaligned, legal;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   lane_wdata, lane_rdata;
  logic [31:0]                 word, rd_fmt;
  logic [AW-1:0]               idx;

  assign idx          = mem_addr[AW+1:2];
  assign out_of_range = (mem_addr[31:28] != BANK_ID) || (|mem_addr[27:AW+2]);
  assign legal        = !out_of_range && !misaligned;
  assign word         = lane_rdata;

  always_comb begin
    misaligned = 1'b1;
    lane_we    = '0;
    lane_wdata = mem_wr_data;
    rd_fmt     = '0;
    case (mem_access)
      MEM_ACCESS_BYTE: begin
        misaligned = 1'b0;
        lane_we    = 4'b0001 << mem_addr[1:0];
        lane_wdata = {4{mem_wr_data[7:0]}};
        rd_fmt     = {24'h0, word[{mem_addr[1:0], 3'b000} +: 8]};
      end
      MEM_ACCESS_HALF: begin
        misaligned = mem_addr[0];
        lane_we    = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{mem_wr_data[15:0]}};
        rd_fmt     = {16'h0, mem_addr[1] ? word[31:16] : word[15:0]};
      end
      MEM_ACCESS_WORD: begin
        misaligned = |mem_addr[1:0];
        lane_we    = 4'b1111;
        rd_fmt     = word;
      end
      default: misaligned = 1'b1;
    endcase
    // Gating with rst keeps stores out of reset cycles and illegal accesses.
    if (!(legal && mem_wr_ena && rst)) lane_we = '0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    memory_responder_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (idx),
      .wdata (lane_wdata[l]),
      .rdata (lane_rdata[l])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_data   <= '0;
      mem_exception <= '0;
      read_count    <= '0;
      write_count   <= '0;
    end else begin
      mem_rd_data                        <= legal ? rd_fmt : 32'h0;
      mem_exception                      <= '0;
      mem_exception[MEM_EXC_MISALIGNED]  <= misaligned;
      mem_exception[MEM_EXC_OUT_OF_RANGE] <= out_of_range;
      if (legal &&  mem_wr_ena) write_count <= write_count + 32'd1;
      if (legal && !mem_wr_ena) read_count  <= read_count + 32'd1;
    end
  end
endmodule
